// File: rtl/btn_cmd_scheduler.sv
// Button command scheduler: debounced press pulses -> round-robin command stream with FIRE cooldown.
// Define BTN_AUTOREPEAT_EN to add LEFT/RIGHT hold-to-repeat.
module btn_cmd_scheduler #(
    parameter int REPEAT_DLY = 6,
    parameter int REPEAT_PER = 2,
    parameter int FIRE_CD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] clean,
    input  logic [3:0] single,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    input  logic       cmd_ready,
    output logic [7:0] drop_cnt
);

    localparam int         CD_W     = (FIRE_CD < 1) ? 1 : $clog2(FIRE_CD + 1);
    localparam logic [1:0] FIRE_IDX = 2'd2;

    logic [3:0]      pending;
    logic [3:0]      evt;
    logic [3:0]      grant;
    logic [1:0]      rr_ptr;
    logic [1:0]      gnt_idx;
    logic [1:0]      cand;
    logic            gnt_any;
    logic            load;
    logic            fire_drop;
    logic [CD_W-1:0] cd_cnt;
    logic            unused_clean_hi;

    assign unused_clean_hi = ^clean[3:2];

`ifdef BTN_AUTOREPEAT_EN
    localparam int DLY_EFF = (REPEAT_DLY < 1) ? 1 : REPEAT_DLY;
    localparam int PER_EFF = (REPEAT_PER < 1) ? 1 : REPEAT_PER;
    localparam int RPT_MAX = (DLY_EFF > PER_EFF) ? DLY_EFF : PER_EFF;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [1:0] rpt_evt;

    for (genvar g = 0; g < 2; g++) begin : g_rpt
        rpt_state_t       state;
        logic [RPT_W-1:0] cnt;
        logic             evt_q;

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= RPT_IDLE;
                cnt   <= '0;
                evt_q <= 1'b0;
            end else begin
                evt_q <= 1'b0;
                if (!clean[g]) begin
                    state <= RPT_IDLE;
                    cnt   <= '0;
                end else begin
                    case (state)
                        RPT_IDLE: begin
                            if (single[g]) begin
                                state <= RPT_DELAY;
                                cnt   <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (tick) begin
                                if (cnt == RPT_W'(DLY_EFF - 1)) begin
                                    state <= RPT_REPEAT;
                                    cnt   <= '0;
                                    evt_q <= 1'b1;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        RPT_REPEAT: begin
                            if (tick) begin
                                if (cnt == RPT_W'(PER_EFF - 1)) begin
                                    cnt   <= '0;
                                    evt_q <= 1'b1;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                        end
                        default: state <= RPT_IDLE;
                    endcase
                end
            end
        end

        assign rpt_evt[g] = evt_q;
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{clean[1:0], REPEAT_DLY[0], REPEAT_PER[0]};
`endif

    // A FIRE press is refused while cooling down or while one FIRE is already queued.
    assign fire_drop = single[2] & ((cd_cnt != '0) | pending[2]);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        evt = single;
`ifdef BTN_AUTOREPEAT_EN
        evt[1:0] = single[1:0] | rpt_evt;
`endif
        evt[2] = single[2] & ~fire_drop;
    end

    assign load = !cmd_valid | cmd_ready;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        cand    = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!gnt_any && pending[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign grant = (load && gnt_any) ? (4'b0001 << gnt_idx) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            rr_ptr    <= 2'd3;
            cmd_valid <= 1'b0;
            cmd_code  <= 2'd0;
        end else begin
            pending <= (pending & ~grant) | evt;
            if (load) begin
                cmd_valid <= gnt_any;
                if (gnt_any) begin
                    cmd_code <= gnt_idx;
                    rr_ptr   <= gnt_idx;
                end
            end
        end
    end

    // Cooldown restarts when FIRE reaches the output register, not when it is pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_cnt <= '0;
        end else if (grant[FIRE_IDX]) begin
            cd_cnt <= CD_W'(FIRE_CD);
        end else if (tick && cd_cnt != '0) begin
            cd_cnt <= cd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (fire_drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Self-checking bench for btn_cmd_scheduler: behavioural model compared every cycle plus directed literals.
module tb_btn_cmd_scheduler;

    localparam int P_DLY = 6;
    localparam int P_PER = 2;
    localparam int P_CD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] clean;
    logic [3:0] single;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic       cmd_ready;
    logic [7:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int code0_seen = 0;

    btn_cmd_scheduler #(
        .REPEAT_DLY(P_DLY),
        .REPEAT_PER(P_PER),
        .FIRE_CD   (P_CD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .clean    (clean),
        .single   (single),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_ready(cmd_ready),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: set of waiting buttons, rotating priority, cooldown in ticks remaining.
    bit [3:0] m_pend  = '0;
    int       m_ptr   = 3;
    bit       m_valid = 1'b0;
    int       m_code  = 0;
    int       m_cd    = 0;
    int       m_drop  = 0;
`ifdef BTN_AUTOREPEAT_EN
    bit       m_active[2];
    int       m_held[2];
    bit       m_rpt[2];
`endif

    always @(posedge clk or posedge rst) begin
        bit [3:0] ev;
        int       g;
        if (rst) begin
            m_pend  = '0;
            m_ptr   = 3;
            m_valid = 1'b0;
            m_code  = 0;
            m_cd    = 0;
            m_drop  = 0;
`ifdef BTN_AUTOREPEAT_EN
            for (int c = 0; c < 2; c++) begin
                m_active[c] = 1'b0;
                m_held[c]   = 0;
                m_rpt[c]    = 1'b0;
            end
`endif
        end else begin
            ev = single;
`ifdef BTN_AUTOREPEAT_EN
            for (int c = 0; c < 2; c++) begin
                bit fire_now;
                ev[c]    = ev[c] | m_rpt[c];
                fire_now = 1'b0;
                if (!clean[c]) begin
                    m_active[c] = 1'b0;
                end else if (!m_active[c]) begin
                    if (single[c]) begin
                        m_active[c] = 1'b1;
                        m_held[c]   = 0;
                    end
                end else if (tick) begin
                    m_held[c]++;
                    if (m_held[c] == P_DLY ||
                        (m_held[c] > P_DLY && (m_held[c] - P_DLY) % P_PER == 0))
                        fire_now = 1'b1;
                end
                m_rpt[c] = fire_now;
            end
`endif
            if (single[2] && (m_cd > 0 || m_pend[2])) begin
                ev[2] = 1'b0;
                if (m_drop < 255) m_drop++;
            end
            g = -1;
            if (!m_valid || cmd_ready) begin
                for (int k = 1; k <= 4; k++)
                    if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_code    = g;
                    m_ptr     = g;
                    m_pend[g] = 1'b0;
                end
            end
            if (g == 2) m_cd = P_CD;
            else if (tick && m_cd > 0) m_cd--;
            m_pend = m_pend | ev;
        end
    end

    always @(negedge clk) begin
        check("cmp_valid", int'(cmd_valid), int'(m_valid));
        if (m_valid) check("cmp_code", int'(cmd_code), m_code);
        check("cmp_drop", int'(drop_cnt), m_drop);
        if (cmd_valid && cmd_code == 2'd0) code0_seen++;
    end

    task automatic drive(input logic [3:0] s, input logic [3:0] c, input logic t, input logic r);
        @(negedge clk);
        single    = s;
        clean     = c;
        tick      = t;
        cmd_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst       = 1'b1;
        single    = '0;
        clean     = '0;
        tick      = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0] s;
        logic       t;
        logic       r;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst       = 1'b1;
        single    = '0;
        clean     = '0;
        tick      = 1'b0;
        cmd_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_code", int'(cmd_code), 0);
        check("rst_drop", int'(drop_cnt), 0);

        // Single FIRE: two-cycle latency, one-cycle command
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("fire_lat1_valid", int'(cmd_valid), 0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("fire_lat2_valid", int'(cmd_valid), 1);
        check("fire_lat2_code", int'(cmd_code), 2);
        check("model_fire_valid", int'(m_valid), 1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("fire_one_cycle", int'(cmd_valid), 0);

        // All four at once from the reset pointer
        do_reset();
        drive(4'b1111, 4'b1111, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0000, 4'b0000, 1'b0, 1'b1);
            check("rr_valid", int'(cmd_valid), 1);
            check("rr_code", int'(cmd_code), k);
        end
        check("model_rr_last", m_code, 3);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("rr_done", int'(cmd_valid), 0);

        // Stall holds START stable, release gives one transfer
        do_reset();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("stall_first_valid", int'(cmd_valid), 1);
        check("stall_first_code", int'(cmd_code), 3);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, 4'b0000, 1'b0, 1'b0);
            check("stall_valid", int'(cmd_valid), 1);
            check("stall_code", int'(cmd_code), 3);
        end
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("stall_released", int'(cmd_valid), 0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("stall_no_repeat", int'(cmd_valid), 0);

        // FIRE cooldown: drops during 4 ticks, boundary at tick 3, accept after tick 4
        do_reset();
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("cd_first_code", int'(cmd_code), 2);
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        repeat (3) drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("cd_drop2", int'(drop_cnt), 2);
        check("cd_no_cmd", int'(cmd_valid), 0);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1, 1'b1);
        drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("cd_after_valid", int'(cmd_valid), 1);
        check("cd_after_code", int'(cmd_code), 2);
        check("cd_drop3", int'(drop_cnt), 3);

        // FIRE already pending is dropped, then saturation of the drop counter
        do_reset();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        drive(4'b0100, 4'b0100, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("pend_drop", int'(drop_cnt), 1);
        check("pend_held_code", int'(cmd_code), 3);
        repeat (5) drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++) drive(4'b0100, 4'b0100, 1'b0, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("drop_sat", int'(drop_cnt), 255);

        // Reset while a command is held and LEFT/RIGHT are pending
        do_reset();
        drive(4'b1000, 4'b1000, 1'b0, 1'b0);
        drive(4'b1010, 4'b0000, 1'b0, 1'b0);
        drive(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("midrst_pre_valid", int'(cmd_valid), 1);
        check("model_midrst_pend", int'(m_pend), 4'b1010);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(cmd_valid), 0);
        check("midrst_code", int'(cmd_code), 0);
        check("midrst_drop", int'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(4'b0000, 4'b0000, 1'b0, 1'b1);
            check("midrst_quiet", int'(cmd_valid), 0);
        end

        // Mixed directed vectors, model-checked every cycle
        do_reset();
        vecs = '{
            '{4'b0011, 1'b0, 1'b1}, '{4'b0000, 1'b0, 1'b0}, '{4'b1100, 1'b0, 1'b0},
            '{4'b0000, 1'b1, 1'b0}, '{4'b0001, 1'b0, 1'b1}, '{4'b0100, 1'b1, 1'b1},
            '{4'b0000, 1'b0, 1'b1}, '{4'b1010, 1'b0, 1'b0}, '{4'b0101, 1'b1, 1'b1},
            '{4'b0000, 1'b0, 1'b0}, '{4'b1111, 1'b1, 1'b1}, '{4'b0000, 1'b0, 1'b1}
        };
        foreach (vecs[i]) drive(vecs[i].s, vecs[i].s, vecs[i].t, vecs[i].r);
        repeat (10) drive(4'b0000, 4'b0000, 1'b1, 1'b1);

        // LEFT held for 12 ticks
        do_reset();
        code0_seen = 0;
        drive(4'b0001, 4'b0001, 1'b0, 1'b1);
        for (int t = 0; t < 12; t++) begin
            drive(4'b0000, 4'b0001, 1'b0, 1'b1);
            drive(4'b0000, 4'b0001, 1'b0, 1'b1);
            drive(4'b0000, 4'b0001, 1'b1, 1'b1);
        end
        drive(4'b0000, 4'b0001, 1'b0, 1'b1);
        drive(4'b0000, 4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) drive(4'b0000, 4'b0000, (i % 3 == 0), 1'b1);
`ifdef BTN_AUTOREPEAT_EN
        check("hold_left_cmds", code0_seen, 5);
`else
        check("hold_left_cmds", code0_seen, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_cmd_scheduler.md
BTN_CMD_SCHEDULER -- requirements
Module: btn_cmd_scheduler

Interface
REQ-001 Parameter REPEAT_DLY, default 6: ticks a held LEFT/RIGHT button must stay held before auto-repeat begins.
REQ-002 Parameter REPEAT_PER, default 2: ticks between successive auto-repeat events.
REQ-003 Parameter FIRE_CD, default 4: FIRE cooldown length in ticks after an accepted FIRE command.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick  input  1  one-cycle timebase strobe for all delay, period and cooldown counting.
REQ-007 clean  input  4  debounced button levels, bit0 LEFT, bit1 RIGHT, bit2 FIRE, bit3 START.
REQ-008 single  input  4  debounced one-cycle press pulses, same bit order.
REQ-009 cmd_valid  output  1  command available.
REQ-010 cmd_code  output  2  command index 0..3, same encoding as button bits.
REQ-011 cmd_ready  input  1  game FSM accepts the command when cmd_valid & cmd_ready.
REQ-012 drop_cnt  output  8  saturating count of FIRE presses discarded during cooldown.

Function
REQ-013 Event sources: single[i] for all bits, plus auto-repeat events for bits 0 and 1 (REQ-017).
REQ-014 pending[i] next = (pending[i] & ~grant[i]) | event[i]; an event coinciding with a grant of the same bit re-sets pending (no loss, no merge beyond one).
REQ-015 Output register loads when !cmd_valid or (cmd_valid & cmd_ready); cmd_valid/cmd_code otherwise hold stable (no change while stalled).
REQ-016 Grant: round-robin over pending, search starts at rr_ptr+1 mod 4; rr_ptr updates to the granted index on each load; at most one grant per cycle; minimum latency single -> cmd_valid is 2 cycles (pending register, then output register).
REQ-017 Per-channel repeat FSM (LEFT, RIGHT): IDLE -> DELAY on single[i]; DELAY counts ticks, -> REPEAT after REPEAT_DLY ticks while clean[i]=1 and emits an event; REPEAT emits an event every REPEAT_PER ticks; any state -> IDLE the cycle after clean[i]=0.
REQ-018 FIRE gating: event accepted into pending only when cd_cnt==0; granting FIRE to the output loads cd_cnt=FIRE_CD; cd_cnt decrements on tick to 0.
REQ-019 FIRE single while cd_cnt!=0 or while FIRE already pending: discarded, drop_cnt increments, saturates at 255.
REQ-020 START has no repeat or cooldown; pending only.
REQ-021 Counters sized ceil(log2(param+1)); parameter 0 for REPEAT_PER treated as 1.
REQ-022 Simultaneous single on all four bits with empty output: grants LEFT, RIGHT, FIRE, START in consecutive accepted cycles from reset pointer.

Reset
REQ-023 On rst: cmd_valid=0, cmd_code=0, pending=0, rr_ptr=3, cd_cnt=0, drop_cnt=0, both repeat FSMs IDLE, tick counters 0.
REQ-024 Reset mid-transaction discards the held command and all pending events; first post-reset command requires a new single.

Configuration
REQ-025 Macro BTN_AUTOREPEAT_EN: defined -> REQ-017 repeat FSMs present; undefined -> repeat logic absent, LEFT/RIGHT generate commands from single only, REPEAT_DLY/REPEAT_PER unused.

Verification
REQ-026 Reset, single=4'b0100 one cycle, cmd_ready=1 -> cmd_valid=1, cmd_code=2 two cycles later, for one cycle.
REQ-027 single=4'b1111 same cycle, cmd_ready=1 -> codes 0,1,2,3 on four consecutive cycles.
REQ-028 cmd_ready=0 for 10 cycles with command code 3 held -> cmd_valid and cmd_code stable; released -> one transfer only.
REQ-029 FIRE press accepted, then two FIRE presses within 4 ticks -> no extra commands, drop_cnt=2; press after 4 ticks -> code 2 issued.
REQ-030 With BTN_AUTOREPEAT_EN, LEFT held 12 ticks, ready=1 -> code 0 at press, at tick 6, 8, 10, 12; release -> no further commands.
REQ-031 rst asserted while cmd_valid=1 and pending=4'b1010 -> all outputs zero next edge, no command after release without new press.
